// File: rtl/suma_serial_ctrl_if.sv
// Purpose : start/operand request and result/flag response bundle for the bit-serial add/sub sequencer.
// Latency : pure wiring, so no latency of its own.
// Backpressure: none. The requester watches busy/done and may only expect a start to be taken while idle.
// Ports   : start, op, a, b  (requester -> sequencer)
//           busy, done, result, cout, ovf  (sequencer -> requester)
interface suma_serial_ctrl_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic             op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] result;
   logic             cout;
   logic             ovf;

   // Requester side (operand/key-entry logic, or the bench)
   modport master (
      output start, op, a, b,
      input  busy, done, result, cout, ovf
   );

   // Sequencer side
   modport slave (
      input  start, op, a, b,
      output busy, done, result, cout, ovf
   );
endinterface

// File: rtl/suma_serial_ctrl.sv
// Purpose : bit-serial add/subtract sequencer. One 1-bit full adder is reused WIDTH times, LSB first,
//           with a registered carry between bits.
// Latency : WIDTH+1 edges from acceptance to the done pulse. A new start can be taken every WIDTH+2 cycles.
// Backpressure: start is taken only in IDLE. It is silently ignored in RUN/DONE, with no queuing.
// Ports   : clk, rst_n (synchronous, active-low), bus (slave modport of suma_serial_ctrl_if).
// Config  : defining SUMA_SUB_EN enables subtraction through op. Without it, op is ignored and the
//           block only adds.
module suma_serial_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   suma_serial_ctrl_if.slave    bus
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state;

   // Operand shift registers consumed LSB first, and the sum register filled from the MSB side
   logic [WIDTH-1:0] sa;
   logic [WIDTH-1:0] sb;
   logic [WIDTH-1:0] sum_sr;
   logic             carry;
   logic [CW-1:0]    cnt;

   // Registered outputs
   logic             busy_q;
   logic             done_q;
   logic [WIDTH-1:0] result_q;
   logic             cout_q;
   logic             ovf_q;

   // Full-adder cell
   logic             cell_s;
   logic             cell_c;
   logic             sub_sel;

   // Subtraction is a + ~b + 1. The +1 enters as the initial carry, so both the
   // operand inversion and the carry seed come from the same select.
`ifdef SUMA_SUB_EN
   assign sub_sel = bus.op;
`else
   logic unused_op;
   assign unused_op = bus.op;
   assign sub_sel   = 1'b0;
`endif

   always_comb begin
      cell_s = sa[0] ^ sb[0] ^ carry;
      cell_c = (sa[0] & sb[0]) | (carry & (sa[0] ^ sb[0]));
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= IDLE;
         sa       <= '0;
         sb       <= '0;
         sum_sr   <= '0;
         carry    <= 1'b0;
         cnt      <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         result_q <= '0;
         cout_q   <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               done_q <= 1'b0;
               if (bus.start) begin
                  sa     <= bus.a;
                  sb     <= sub_sel ? ~bus.b : bus.b;
                  carry  <= sub_sel;
                  cnt    <= '0;
                  busy_q <= 1'b1;
                  state  <= RUN;
               end
            end

            RUN: begin
               sum_sr <= {cell_s, sum_sr[WIDTH-1:1]};
               sa     <= sa >> 1;
               sb     <= sb >> 1;
               carry  <= cell_c;
               if (cnt == LAST_BIT) begin
                  // On the MSB cycle the sum register still lacks this bit, so the
                  // result is taken directly from the shift input.
                  result_q <= {cell_s, sum_sr[WIDTH-1:1]};
                  cout_q   <= cell_c;
                  // carry currently holds the carry into the MSB
                  ovf_q    <= carry ^ cell_c;
                  busy_q   <= 1'b0;
                  done_q   <= 1'b1;
                  state    <= DONE;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end

            DONE: begin
               done_q <= 1'b0;
               state  <= IDLE;
            end

            default: begin
               busy_q <= 1'b0;
               done_q <= 1'b0;
               state  <= IDLE;
            end
         endcase
      end
   end

   assign bus.busy   = busy_q;
   assign bus.done   = done_q;
   assign bus.result = result_q;
   assign bus.cout   = cout_q;
   assign bus.ovf    = ovf_q;

   // Structural invariants of the sequencer
   a_busy_done_excl: assert property (@(posedge clk) disable iff (!rst_n) !(busy_q && done_q));
   a_done_one_cycle: assert property (@(posedge clk) disable iff (!rst_n) done_q |=> !done_q);

endmodule
